// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-32 demux / serial collector.
package demux_pkg;

  localparam int unsigned SEL_W   = 5;
  localparam int unsigned NUM_OUT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dec5to32.sv
// Combinational 5-bit to 32-bit one-hot decoder; drives the per-position write enables.
module dec5to32 (
  input  logic [4:0]  sel,
  output logic [31:0] onehot
);

  import demux_pkg::*;

  // Exactly one bit set for every select value; no out-of-range case exists.
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux32_collect.sv
// Registered 1-to-32 demux with an LSB-first sweep collector that rebuilds 32-bit words.
module demux32_collect #(
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             mode,
  input  logic             start,
  output logic [31:0]      out,
  output logic [31:0]      word_out,
  output logic             word_valid,
  output logic             busy,
  output logic [SEL_W-1:0] sweep_idx
);

  import demux_pkg::*;

  state_t             state_q;
  logic [31:0]        out_q;
  logic [31:0]        word_out_q;
  logic               word_valid_q;
  logic [SEL_W-1:0]   sweep_idx_q;
  logic [SEL_W-1:0]   wr_idx;
  logic [31:0]        wr_en;
  logic [31:0]        wr_word;
  logic               restart;

  // A sweep restart needs mode=1 on the start pulse; mode is ignored otherwise.
  assign restart = start && mode;

  // Write position: sweep counter while collecting, explicit select otherwise.
  always_comb begin
    wr_idx = (state_q == SWEEP) ? sweep_idx_q : in_sel;
  end

  dec5to32 u_dec (
    .sel    (wr_idx),
    .onehot (wr_en)
  );

  // Candidate register value with in_bit merged into the enabled position only.
  always_comb begin
    wr_word = (out_q & ~wr_en) | (wr_en & {32{in_bit}});
  end

  // FSM, sweep counter and all output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_q        <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      sweep_idx_q  <= '0;
    end else begin
      word_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (restart) begin
            out_q       <= '0;
            sweep_idx_q <= '0;
            state_q     <= SWEEP;
          end else if (in_valid && !mode) begin
            out_q <= wr_word;
          end
        end
        SWEEP: begin
          if (restart) begin
            // Abort: partial word is discarded, no completion pulse.
            out_q       <= '0;
            sweep_idx_q <= '0;
          end else if (in_valid) begin
            out_q       <= wr_word;
            sweep_idx_q <= sweep_idx_q + 1'b1;
            if (sweep_idx_q == SEL_W'(31)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // Completed word is published even if a new sweep starts now.
          word_out_q   <= out_q;
          word_valid_q <= 1'b1;
          if (restart) begin
            out_q       <= '0;
            sweep_idx_q <= '0;
            state_q     <= SWEEP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out        = out_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign busy       = (state_q == SWEEP);
  assign sweep_idx  = sweep_idx_q;

endmodule

// File: tb/tb_demux32_collect.sv
// Directed bench for demux32_collect: addressed writes, sweeps, gaps, restart and reset.
module tb_demux32_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_bit;
  logic        in_valid;
  logic [4:0]  in_sel;
  logic        mode;
  logic        start;
  logic [31:0] out;
  logic [31:0] word_out;
  logic        word_valid;
  logic        busy;
  logic [4:0]  sweep_idx;

  int n_chk = 0;
  int n_fail = 0;
  int wv_cnt = 0;
  int wv_double = 0;
  logic wv_prev = 1'b0;
  int wv_base;

  demux32_collect #(.SEL_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .mode       (mode),
    .start      (start),
    .out        (out),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .sweep_idx  (sweep_idx)
  );

  always #5 clk = ~clk;

  // Count completion pulses and back-to-back highs, sampled mid-cycle.
  always @(negedge clk) begin
    if (word_valid) wv_cnt <= wv_cnt + 1;
    if (word_valid && wv_prev) wv_double <= wv_double + 1;
    wv_prev <= word_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_sel = '0; mode = 1'b0; start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Start a sweep, then deliver nbits of val LSB first. A gap is inserted on every
  // gap_every-th cycle; noise drives in_sel=7 and toggles mode while sweeping.
  task automatic do_sweep(input logic [31:0] val, input int nbits, input int gap_every,
                          input bit noise);
    int k;
    int c;
    logic [4:0] exp_idx;
    mode = 1'b1; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    k = 0;
    c = 0;
    while (k < nbits) begin
      if (noise) begin
        in_sel = 5'd7;
        mode   = c[0];
      end
      if (gap_every != 0 && (c % gap_every) == gap_every - 1) begin
        in_valid = 1'b0;
        in_bit   = ~in_bit;
        tick();
        exp_idx = 5'(k);
        chk("gap_idx_hold", {27'd0, sweep_idx}, {27'd0, exp_idx});
      end else begin
        in_valid = 1'b1;
        in_bit   = val[k];
        tick();
        k++;
      end
      c++;
    end
    in_valid = 1'b0;
    mode     = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out", out, 32'h0);
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sweep_idx", {27'd0, sweep_idx}, 32'd0);

    // Sweep 0xDEADBEEF back-to-back; word_valid 33 edges after start
    wv_base = wv_cnt;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw1_busy_after_start", {31'd0, busy}, 32'd1);
    chk("sw1_idx_after_start", {27'd0, sweep_idx}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = 32'hDEADBEEF;
      in_valid = 1'b1;
      in_bit   = v[i];
      tick();
      if (i == 31) begin
        chk("sw1_wv_low_at_32", {31'd0, word_valid}, 32'd0);
      end
      in_valid = 1'b0;
    end
    chk("sw1_out", out, 32'hDEADBEEF);
    chk("sw1_idx_wrap", {27'd0, sweep_idx}, 32'd0);
    chk("sw1_busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    chk("sw1_wv_edge33", {31'd0, word_valid}, 32'd1);
    chk("sw1_word_out", word_out, 32'hDEADBEEF);
    tick();
    chk("sw1_wv_drop", {31'd0, word_valid}, 32'd0);
    chk("sw1_busy_after", {31'd0, busy}, 32'd0);
    chk("sw1_word_hold", word_out, 32'hDEADBEEF);
    chk("sw1_wv_count", wv_cnt - wv_base, 32'd1);

    // Addressed mode
    do_reset();
    wv_base = wv_cnt;
    mode = 1'b0; in_valid = 1'b1;
    in_sel = 5'd31; in_bit = 1'b1;
    tick();
    chk("addr_31_set", out, 32'h8000_0000);
    in_sel = 5'd0; in_bit = 1'b1;
    tick();
    chk("addr_0_set", out, 32'h8000_0001);
    in_sel = 5'd31; in_bit = 1'b0;
    tick();
    chk("addr_31_clr", out, 32'h0000_0001);
    in_valid = 1'b0;
    in_sel = 5'd5; in_bit = 1'b1;
    tick();
    chk("addr_no_valid_hold", out, 32'h0000_0001);
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("addr_start_mode0_ignored", {31'd0, busy}, 32'd0);
    tick();
    chk("addr_no_wv", wv_cnt - wv_base, 32'd0);

    // Gaps on every third cycle
    do_reset();
    wv_base = wv_cnt;
    do_sweep(32'hA5A5A5A5, 32, 3, 1'b0);
    tick();
    chk("gap_wv", {31'd0, word_valid}, 32'd1);
    chk("gap_word_out", word_out, 32'hA5A5A5A5);
    tick();
    chk("gap_wv_count", wv_cnt - wv_base, 32'd1);

    // Restart: 16 ones aborted, then 0x12345678
    wv_base = wv_cnt;
    do_sweep(32'hFFFFFFFF, 16, 0, 1'b0);
    chk("rs_partial_out", out, 32'h0000FFFF);
    do_sweep(32'h12345678, 32, 0, 1'b0);
    tick();
    chk("rs_word_out", word_out, 32'h12345678);
    tick();
    chk("rs_wv_count", wv_cnt - wv_base, 32'd1);

    // Reset mid-sweep after 10 bits
    wv_base = wv_cnt;
    do_sweep(32'hFFFFFFFF, 10, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_out", out, 32'h0);
    chk("mrst_word_out", word_out, 32'h0);
    chk("mrst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_idx", {27'd0, sweep_idx}, 32'd0);
    tick();
    chk("mrst_no_wv", wv_cnt - wv_base, 32'd0);
    do_sweep(32'hFFFFFFFF, 32, 0, 1'b0);
    tick();
    chk("mrst_full_word", word_out, 32'hFFFFFFFF);

    // Sweep ignores in_sel and mode toggles
    tick();
    do_sweep(32'h0000FFFF, 32, 0, 1'b1);
    tick();
    chk("noise_wv", {31'd0, word_valid}, 32'd1);
    chk("noise_word_out", word_out, 32'h0000FFFF);
    tick();
    tick();
    chk("wv_never_double", wv_double, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
